// File: rtl/nav_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nav_scan_sequencer
// Purpose  : Rover navigation controller. Drives forward while the path is
//            clear; on an obstacle it settles, scans right then left through
//            a request/done ranging handshake and pivots to the clearer
//            heading. All outputs are registered.
// Options  : NAV_ALERT_EN adds a registered 'alert' output for the beeper.
// Revision : 1.0  initial release
// ============================================================================
module nav_scan_sequencer #(
    parameter int DIST_W        = 16,
    parameter int STOP_CM       = 25,
    parameter int TURN_CYCLES   = 50000000,
    parameter int SETTLE_CYCLES = 5000000,
    parameter int MEAS_TIMEOUT  = 3000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    output logic              meas_req,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] meas_dist,
    output logic [1:0]        motor_state,
    output logic              scanning,
`ifdef NAV_ALERT_EN
    output logic              alert,
`endif
    output logic [DIST_W-1:0] last_dist
);

    localparam int TMAX = (2 * TURN_CYCLES > SETTLE_CYCLES) ? 2 * TURN_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int MW   = $clog2(MEAS_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        MEAS_FWD = 4'd1,
        DRIVE    = 4'd2,
        SETTLE   = 4'd3,
        TURN_R   = 4'd4,
        MEAS_R   = 4'd5,
        TURN_L2  = 4'd6,
        MEAS_L   = 4'd7,
        DECIDE   = 4'd8,
        TURN_R2  = 4'd9,
        TURN_L1  = 4'd10
    } state_t;

    state_t            state, state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [MW-1:0]     meas_cnt;
    logic [DIST_W-1:0] dist_r, dist_l;
    logic              timeout, accept, acc_clear, timer_done;
    logic [DIST_W-1:0] acc_dist;
    logic              req_n, scan_n;
    logic [1:0]        motor_n;

    function automatic logic [1:0] motor_of(input state_t s);
        case (s)
            DRIVE:                    motor_of = 2'b11;
            TURN_R, TURN_R2:          motor_of = 2'b01;
            TURN_L2, TURN_L1:         motor_of = 2'b10;
            default:                  motor_of = 2'b00;
        endcase
    endfunction

    function automatic logic is_meas(input state_t s);
        is_meas = (s == MEAS_FWD) || (s == DRIVE) || (s == MEAS_R) || (s == MEAS_L);
    endfunction

    function automatic logic is_scan(input state_t s);
        is_scan = !((s == IDLE) || (s == MEAS_FWD) || (s == DRIVE));
    endfunction

    function automatic logic [TW-1:0] dwell_of(input state_t s);
        case (s)
            SETTLE:           dwell_of = TW'(SETTLE_CYCLES);
            TURN_R, TURN_L1:  dwell_of = TW'(TURN_CYCLES);
            TURN_L2, TURN_R2: dwell_of = TW'(2 * TURN_CYCLES);
            default:          dwell_of = '0;
        endcase
    endfunction

    // Handshake qualification: a measurement is accepted on done or timeout
    // only while requesting; halt suppresses acceptance in the same cycle.
    always_comb begin
        timeout    = meas_req && !meas_done && (meas_cnt == MW'(MEAS_TIMEOUT - 1));
        accept     = !halt && meas_req && (meas_done || timeout);
        acc_dist   = meas_done ? meas_dist : {DIST_W{1'b1}};
        acc_clear  = (acc_dist >= DIST_W'(STOP_CM));
        timer_done = (timer == TW'(1));
    end

    // Next-state, timer reload and next registered output values.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (start) state_n = MEAS_FWD;
            MEAS_FWD: if (accept) state_n = acc_clear ? DRIVE : SETTLE;
            DRIVE:    if (accept && !acc_clear) state_n = SETTLE;
            SETTLE:   if (timer_done) state_n = TURN_R;
            TURN_R:   if (timer_done) state_n = MEAS_R;
            MEAS_R:   if (accept) state_n = TURN_L2;
            TURN_L2:  if (timer_done) state_n = MEAS_L;
            MEAS_L:   if (accept) state_n = DECIDE;
            DECIDE: begin
                // Ties between equal clear headings keep the left one.
                if ((dist_l >= DIST_W'(STOP_CM)) && (dist_l >= dist_r))
                    state_n = MEAS_FWD;
                else if (dist_r >= DIST_W'(STOP_CM))
                    state_n = TURN_R2;
                else
                    state_n = TURN_L1;
            end
            TURN_R2:  if (timer_done) state_n = MEAS_FWD;
            TURN_L1:  if (timer_done) state_n = MEAS_FWD;
            default:  state_n = IDLE;
        endcase
        if (halt) state_n = IDLE;

        if (state_n != state)
            timer_n = dwell_of(state_n);
        else if (timer != '0)
            timer_n = timer - TW'(1);
        else
            timer_n = timer;

        // Request drops for one cycle after every accepted measurement.
        req_n   = is_meas(state_n) && !accept;
        motor_n = motor_of(state_n);
        scan_n  = is_scan(state_n);
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            meas_req    <= 1'b0;
            motor_state <= 2'b00;
            scanning    <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            meas_req    <= req_n;
            motor_state <= motor_n;
            scanning    <= scan_n;
        end
    end

    // Timeout counter restarts from zero whenever the request rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            meas_cnt <= '0;
        else if (!meas_req)
            meas_cnt <= '0;
        else
            meas_cnt <= meas_cnt + MW'(1);
    end

    // Capture accepted distances for the scan decision and the status output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dist <= '0;
            dist_r    <= '0;
            dist_l    <= '0;
        end else if (accept) begin
            last_dist <= acc_dist;
            if (state == MEAS_R) dist_r <= acc_dist;
            if (state == MEAS_L) dist_l <= acc_dist;
        end
    end

`ifdef NAV_ALERT_EN
    // Beeper alert: active throughout the scan and any corrective pivot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alert <= 1'b0;
        else
            alert <= scan_n || (state_n == TURN_L1);
    end
`endif

endmodule
`default_nettype wire

// File: doc/nav_scan_sequencer.md
Name: nav_scan_sequencer

Overview:
- Top-level rover navigation controller. It sequences the ultrasonic ranging unit through a request/done handshake and drives the 2-bit motor command into the motor driver.
- It drives forward while the path is clear. On an obstacle it performs a right/left scan, then picks the clearer heading.
- It replaces the free-running distance polling with an explicit, timed state machine.

Parameters:
- DIST_W, 16, width of distance values in cm
- STOP_CM, 25, obstacle threshold; dist < STOP_CM is blocked
- TURN_CYCLES, 50000000, clk cycles for one 90° pivot
- SETTLE_CYCLES, 5000000, motors-off dwell before the first scan turn
- MEAS_TIMEOUT, 3000000, max cycles to wait for meas_done

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse (synchronised motion-sensor event); honoured only in IDLE
- halt  in  1  synchronous abort; any state -> IDLE next cycle, motors off
- meas_req  out  1  request one range measurement
- meas_done  in  1  one-cycle pulse; meas_dist valid this cycle
- meas_dist  in  DIST_W  measured distance, cm
- motor_state  out  2  00 stop, 01 pivot right, 10 pivot left, 11 forward
- scanning  out  1  high in SETTLE, TURN_*, MEAS_R, MEAS_L, DECIDE
- last_dist  out  DIST_W  most recent accepted distance

Behaviour:
- Reset (async, rst_n=0): state IDLE, motor_state=00, meas_req=0, scanning=0, last_dist=0, timers cleared, dist_r/dist_l cleared. Asserting reset mid-turn stops the motors immediately.
- All outputs are registered.
- Measurement handshake:
  - meas_req rises on entry to a measuring state (MEAS_FWD, DRIVE, MEAS_R, MEAS_L). It stays high until meas_done or timeout.
  - meas_req is low for exactly 1 cycle after each done/timeout, then re-asserts if the state still measures.
  - The timeout counter clears on each meas_req rise.
  - Timeout (MEAS_TIMEOUT cycles with no done) = accepted distance of all-ones (out of range, clear).
  - meas_done while meas_req=0 is ignored.
- States (motor_state in brackets):
  - IDLE [00]: start -> MEAS_FWD.
  - MEAS_FWD [00]: accepted dist >= STOP_CM -> DRIVE; < STOP_CM -> SETTLE.
  - DRIVE [11]: measures continuously. Each accepted dist >= STOP_CM stays in DRIVE; < STOP_CM -> SETTLE the next cycle, motors 00.
  - SETTLE [00]: SETTLE_CYCLES -> TURN_R.
  - TURN_R [01]: TURN_CYCLES -> MEAS_R.
  - MEAS_R [00]: store dist_r -> TURN_L2.
  - TURN_L2 [10]: 2*TURN_CYCLES -> MEAS_L.
  - MEAS_L [00]: store dist_l -> DECIDE.
  - DECIDE [00], 1 cycle:
    - dist_l >= STOP_CM and dist_l >= dist_r -> MEAS_FWD (already facing left; ties prefer left).
    - else dist_r >= STOP_CM -> TURN_R2 [01, 2*TURN_CYCLES] -> MEAS_FWD.
    - else (both blocked) -> TURN_L1 [10, TURN_CYCLES] -> MEAS_FWD (reversed heading).
- Timers: a single down-counter, width sized for 2*TURN_CYCLES, loaded on state entry. The state exits on the cycle it reaches 1, so a dwell is exactly N cycles of the stated motor_state.
- last_dist updates on every accepted measurement.
- Distance compares are unsigned, full DIST_W.
- halt has priority over start, meas_done and timer expiry in the same cycle.
- start outside IDLE is ignored.

Optional Feature:
- Macro: NAV_ALERT_EN.
- Defined: adds output port alert (1 bit), registered, high whenever scanning=1 or state==TURN_L1. It feeds the LED/speaker beeper; reset value 0.
- Undefined: no alert port and no associated logic; all other behaviour is identical.

Test Plan:
All scenarios use TURN_CYCLES=20, SETTLE_CYCLES=4, MEAS_TIMEOUT=50, STOP_CM=25.

1. Clear path: start pulse; ranger answers 100 each request -> meas_req next cycle; MEAS_FWD then DRIVE; motor_state=11 held; last_dist=100; meas_req low exactly 1 cycle between requests.
2. Obstacle, right best: DRIVE, then dist=10 -> 00 for 4 cycles, 01 for 20, measure r=80, 10 for 40, measure l=30, DECIDE -> 01 for 40 -> MEAS_FWD; scanning high throughout.
3. Tie and both-blocked:
   - r=l=60 -> left chosen, straight to MEAS_FWD with no further turn.
   - r=5, l=12 -> 10 for 20 cycles, then MEAS_FWD.
4. Timeout: no meas_done for 50 cycles in MEAS_FWD -> last_dist=16'hFFFF, state DRIVE, motor 11.
5. halt during TURN_L2 cycle 10 plus simultaneous meas_done -> IDLE next cycle, motor 00, meas_req 0; a later start restarts from MEAS_FWD.
6. Async reset: rst_n low mid-TURN_R -> motor_state=00 without a clock edge, all outputs at reset values. NAV_ALERT_EN build: alert follows scanning in scenario 2.
